// File: rtl/spi_bus_arb.sv
// spi_bus_arb: round-robin arbiter sharing one SPI master among three requesters,
// driving the wrt/cmd handshake and one active-low slave select per transaction.
module spi_bus_arb #(
  parameter int NUM_REQ = 3,
  parameter int GAP_CYC = 4,
  parameter int TO_CYC  = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  req,
  input  logic [8:0]  tgt,
  input  logic [47:0] wdata,
  output logic [2:0]  ack,
  output logic [2:0]  err,
  output logic [15:0] rdata,
  output logic        busy,
  output logic        spi_wrt,
  output logic [15:0] spi_cmd,
  input  logic        spi_done,
  input  logic [15:0] spi_rd,
  output logic        ch1_ss_n,
  output logic        ch2_ss_n,
  output logic        ch3_ss_n,
  output logic        trig_ss_n,
  output logic        EEP_ss_n
);
  localparam int TW = $clog2(TO_CYC);
  localparam int GW = $clog2(GAP_CYC) + 1;
  typedef enum logic [2:0] {IDLE, SETUP, XFER, ACK, ERR, GAP} state_t;
  state_t state, state_n;
  logic [1:0] rr_ptr, ptr_n, gnt, gnt_n, pick;
  logic [2:0] tgt_q, tgt_n, tgt_sel;
  logic [15:0] cmd_n, rd_n;
  logic [TW-1:0] to_cnt, cnt_n;
  logic [GW-1:0] gap_cnt, gap_n;
  logic [4:0] ss_n;

  function automatic logic [1:0] wrap(input logic [2:0] s);
    return (s >= 3'(NUM_REQ)) ? 2'(s - 3'(NUM_REQ)) : s[1:0];
  endfunction

  // Scan downward so the nearest set request at or after rr_ptr wins.
  always_comb begin
    pick = rr_ptr;
    for (int i = NUM_REQ - 1; i >= 0; i--)
      if (req[wrap({1'b0, rr_ptr} + 3'(i))]) pick = wrap({1'b0, rr_ptr} + 3'(i));
  end

  assign tgt_sel = tgt[3*pick +: 3];

  always_comb begin
    state_n = state;
    gnt_n   = gnt;
    tgt_n   = tgt_q;
    cmd_n   = spi_cmd;
    rd_n    = rdata;
    cnt_n   = to_cnt;
    gap_n   = gap_cnt;
    ptr_n   = rr_ptr;
    case (state)
      IDLE: if (|req) begin
        gnt_n   = pick;
        tgt_n   = tgt_sel;
        cmd_n   = wdata[16*pick +: 16];
        cnt_n   = '0;
        state_n = (tgt_sel <= 3'd4) ? SETUP : ERR;
      end
      SETUP: state_n = XFER;
      XFER: begin
        cnt_n = to_cnt + 1'b1;
        if (spi_done) begin
          rd_n    = spi_rd;
          state_n = ACK;
        end else if (to_cnt == TW'(TO_CYC - 2)) state_n = ERR;
      end
      ACK, ERR: begin
        ptr_n   = wrap({1'b0, gnt} + 3'd1);
        gap_n   = '0;
        state_n = GAP;
      end
      GAP: begin
        gap_n   = gap_cnt + 1'b1;
        state_n = (gap_cnt == GW'(GAP_CYC - 1)) ? IDLE : GAP;
      end
      default: state_n = IDLE;
    endcase
  end

  // Outputs are registered from the next-state view so they line up with the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      rr_ptr  <= '0;
      gnt     <= '0;
      tgt_q   <= '0;
      to_cnt  <= '0;
      gap_cnt <= '0;
      ack     <= '0;
      err     <= '0;
      rdata   <= '0;
      busy    <= 1'b0;
      spi_wrt <= 1'b0;
      spi_cmd <= '0;
      ss_n    <= '1;
    end else begin
      state   <= state_n;
      rr_ptr  <= ptr_n;
      gnt     <= gnt_n;
      tgt_q   <= tgt_n;
      to_cnt  <= cnt_n;
      gap_cnt <= gap_n;
      rdata   <= rd_n;
      spi_cmd <= cmd_n;
      ack     <= (state_n == ACK || state_n == ERR) ? 3'b001 << gnt_n : '0;
      err     <= (state_n == ERR) ? 3'b001 << gnt_n : '0;
      busy    <= state_n != IDLE;
      spi_wrt <= state == SETUP;
      ss_n    <= (state_n == SETUP || state_n == XFER) ? ~(5'b00001 << tgt_n) : '1;
    end
  end

  assign {EEP_ss_n, trig_ss_n, ch3_ss_n, ch2_ss_n, ch1_ss_n} = ss_n;
endmodule

// File: tb/tb_spi_bus_arb.sv
// tb_spi_bus_arb: table-driven transactions plus directed reset/stray-done sequences.
module tb_spi_bus_arb;
  localparam int GAP_CYC = 4;
  localparam int TO_CYC  = 4096;
  logic clk = 1'b0;
  logic rst, spi_done, busy, spi_wrt;
  logic [2:0] req, ack, err;
  logic [8:0] tgt;
  logic [47:0] wdata;
  logic [15:0] rdata, spi_cmd, spi_rd;
  logic ch1_ss_n, ch2_ss_n, ch3_ss_n, trig_ss_n, EEP_ss_n;
  logic [4:0] ss_n;
  logic [15:0] mrd;
  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    logic        rst_first;
    logic [2:0]  req;
    logic [8:0]  tgt;
    logic [47:0] wdata;
    int          dly;
    logic [15:0] rd;
    int          gnt;
    logic        e;
  } vec_t;
  vec_t v [8];

  always #5 clk = ~clk;
  assign ss_n = {EEP_ss_n, trig_ss_n, ch3_ss_n, ch2_ss_n, ch1_ss_n};

  spi_bus_arb dut (
    .clk(clk), .rst(rst), .req(req), .tgt(tgt), .wdata(wdata),
    .ack(ack), .err(err), .rdata(rdata), .busy(busy),
    .spi_wrt(spi_wrt), .spi_cmd(spi_cmd), .spi_done(spi_done), .spi_rd(spi_rd),
    .ch1_ss_n(ch1_ss_n), .ch2_ss_n(ch2_ss_n), .ch3_ss_n(ch3_ss_n),
    .trig_ss_n(trig_ss_n), .EEP_ss_n(EEP_ss_n)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic txn(input vec_t r);
    logic [2:0] tg, a, e;
    logic [4:0] mask;
    logic [15:0] cmd, rd;
    logic valid;
    int t, wrt_at, wrt_cnt, low, multi, exp_t, gap, extra;
    if (r.rst_first) begin
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      mrd = 16'h0;
    end
    tg    = r.tgt[3*r.gnt +: 3];
    valid = tg <= 3'd4;
    exp_t = !valid ? 1 : (r.dly != 0) ? r.dly + 3 : TO_CYC + 1;
    req = r.req; tgt = r.tgt; wdata = r.wdata; spi_rd = r.rd;
    t = 0; wrt_at = 0; wrt_cnt = 0; low = 0; multi = 0;
    mask = '0; a = '0; e = '0; cmd = '0; rd = '0;
    while (a == 3'b000 && t < 6000) begin
      @(negedge clk);
      t++;
      if (spi_wrt) begin
        wrt_cnt++;
        if (wrt_at == 0) begin wrt_at = t; cmd = spi_cmd; end
      end
      if (ss_n != 5'h1f) low++;
      mask = mask | ~ss_n;
      if ($countones(~ss_n) > 1) multi = 1;
      spi_done = r.dly != 0 && wrt_at != 0 && t == wrt_at + r.dly;
      a = ack; e = err; rd = rdata;
    end
    if (!r.e) mrd = r.rd;
    chk("ack", a, 3'b001 << r.gnt);
    chk("err", e, r.e ? 3'b001 << r.gnt : 3'b000);
    chk("rdata", rd, mrd);
    chk("ack_time", t, exp_t);
    chk("ss_low_cycles", low, exp_t - 1);
    chk("wrt_count", wrt_cnt, valid);
    chk("one_ss_low", multi, 0);
    if (valid) begin
      chk("wrt_time", wrt_at, 2);
      chk("spi_cmd", cmd, r.wdata[16*r.gnt +: 16]);
      chk("ss_select", mask, 5'b00001 << tg);
    end else chk("ss_select", mask, 5'b00000);
    // Requester drops req; a stray done lands mid-GAP and must be ignored.
    req = 3'b000; spi_rd = 16'hDEAD; gap = 0; extra = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      spi_done = (k == 2);
      if (ack != 3'b000 || ss_n != 5'h1f) extra++;
      if (!busy) break;
      gap++;
    end
    spi_done = 1'b0;
    chk("gap_len", gap, GAP_CYC);
    chk("gap_quiet", extra, 0);
    chk("rdata_hold", rdata, mrd);
  endtask

  initial begin
    int t;
    rst = 1'b1; req = '0; tgt = '0; wdata = '0; spi_done = 1'b0; spi_rd = '0; mrd = '0;
    v[0] = '{1'b0, 3'b001, 9'o000, 48'h0000_0000_1305, 20, 16'h00A5, 0, 1'b0};
    v[1] = '{1'b1, 3'b111, 9'o143, 48'hC222_B111_A000, 3,  16'h1111, 0, 1'b0};
    v[2] = '{1'b0, 3'b111, 9'o143, 48'hC222_B111_A000, 5,  16'h2222, 1, 1'b0};
    v[3] = '{1'b0, 3'b111, 9'o143, 48'hC222_B111_A000, 7,  16'h3333, 2, 1'b0};
    v[4] = '{1'b0, 3'b111, 9'o143, 48'hC222_B111_A000, 2,  16'h4444, 0, 1'b0};
    v[5] = '{1'b0, 3'b010, 9'o060, 48'h0000_DEAD_0000, 3,  16'h6666, 1, 1'b1};
    v[6] = '{1'b0, 3'b011, 9'o012, 48'h0000_7777_5555, 4,  16'h5A5A, 0, 1'b0};
    v[7] = '{1'b0, 3'b100, 9'o400, 48'h9ABC_0000_0000, 0,  16'hFFFF, 2, 1'b1};
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_ack", ack, 3'b000);
    chk("rst_err", err, 3'b000);
    chk("rst_rdata", rdata, 16'h0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_wrt", spi_wrt, 1'b0);
    chk("rst_cmd", spi_cmd, 16'h0);
    chk("rst_ss", ss_n, 5'h1f);
    for (int i = 0; i < 8; i++) txn(v[i]);
    // Stray done while idle.
    spi_rd = 16'hDEAD; spi_done = 1'b1;
    @(negedge clk);
    spi_done = 1'b0;
    chk("idle_stray_ack", ack, 3'b000);
    chk("idle_stray_busy", busy, 1'b0);
    @(negedge clk);
    chk("idle_stray_rdata", rdata, mrd);
    chk("idle_stray_busy2", busy, 1'b0);
    // Reset in the middle of a transfer.
    req = 3'b010; tgt = 9'o020; wdata = 48'h0000_3C3C_0000; spi_rd = 16'hBEEF;
    t = 0;
    while (!spi_wrt && t < 20) begin @(negedge clk); t++; end
    chk("mid_wrt_seen", spi_wrt, 1'b1);
    repeat (5) @(negedge clk);
    chk("mid_ch3_low", ss_n, 5'b11011);
    rst = 1'b1; req = 3'b000;
    @(negedge clk);
    rst = 1'b0; mrd = 16'h0;
    chk("mid_rst_ss", ss_n, 5'h1f);
    chk("mid_rst_ack", ack, 3'b000);
    chk("mid_rst_busy", busy, 1'b0);
    spi_done = 1'b1;
    @(negedge clk);
    spi_done = 1'b0;
    chk("late_done_ack", ack, 3'b000);
    chk("late_done_busy", busy, 1'b0);
    @(negedge clk);
    chk("late_done_rdata", rdata, 16'h0);
    chk("late_done_busy2", busy, 1'b0);
    txn('{1'b0, 3'b011, 9'o021, 48'h0000_2222_1111, 2, 16'h0F0F, 0, 1'b0});
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/spi_bus_arb.md
Name: spi_bus_arb

Overview:
- Shares the single SPI master among the DSO's SPI requesters: the analog-gain/trigger-level pot writer, the EEPROM calibration accessor and the spare/debug port.
- Round-robin arbitration, one transaction at a time.
- Drives the SPI master's wrt/cmd handshake and asserts exactly one slave select (ch1, ch2, ch3, trig, EEP) per transaction.
- Returns read data and a done/error pulse to the granted requester.

Parameters:
- NUM_REQ, 3, number of requesters (fixed at 3 for this revision).
- GAP_CYC, 4, minimum clk cycles with all SS_n high between transactions.
- TO_CYC, 4096, clk cycles allowed for spi_done after spi_wrt before timeout.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- req  in  3  per-requester request, level, held until ack
- tgt  in  9  3-bit target per requester, [3i+2:3i]: 0=ch1, 1=ch2, 2=ch3, 3=trig, 4=EEP, 5-7 invalid
- wdata  in  48  16-bit SPI command per requester, [16i+15:16i]
- ack  out  3  one-cycle completion pulse to the granted requester
- err  out  3  one-cycle error pulse, coincident with ack (invalid target or timeout)
- rdata  out  16  MISO word of the last transfer; valid from the ack cycle, held until the next ack
- busy  out  1  high in any state but IDLE
- spi_wrt  out  1  one-cycle start pulse to the SPI master
- spi_cmd  out  16  command word to the SPI master
- spi_done  in  1  SPI master transfer-complete pulse
- spi_rd  in  16  SPI master received word
- ch1_ss_n, ch2_ss_n, ch3_ss_n, trig_ss_n, EEP_ss_n  out  1 each  active-low slave selects

Behaviour:
- Reset (sync, rst=1 at a clk edge):
  - state=IDLE, rr_ptr=0.
  - All outputs: ack=0, err=0, rdata=0, busy=0, spi_wrt=0, spi_cmd=0.
  - All ss_n=1.
  - Timeout and gap counters=0.
  - Applies mid-transfer too: ss_n go high at that edge and no ack is issued for the aborted transaction.
- Outputs are registered. Exactly one ss_n is low at a time, only in SETUP/XFER.
- States: IDLE, SETUP, XFER, ACK, ERR, GAP.
- IDLE:
  - If req!=0, grant the first set bit searching from rr_ptr upward with wrap.
  - Latch gnt, the granted tgt and the granted wdata into spi_cmd.
  - Valid tgt -> SETUP. Invalid tgt -> ERR.
- SETUP: one cycle. Target ss_n low (setup time before SCLK). Next -> XFER with spi_wrt=1 for the first XFER cycle only.
- XFER:
  - ss_n stays low; the timeout counter increments each cycle.
  - spi_done=1: latch rdata=spi_rd, -> ACK.
  - Counter reaches TO_CYC-1 without done: -> ERR with timeout flag set.
- ACK: ss_n high, ack[gnt]=1 for one cycle, rr_ptr=(gnt+1) mod NUM_REQ, -> GAP.
- ERR:
  - ack[gnt]=1 and err[gnt]=1 for one cycle; all ss_n high; rr_ptr advances as in ACK; -> GAP.
  - Invalid target: no spi_wrt is ever issued.
  - Timeout: rdata is unchanged.
- GAP: GAP_CYC cycles with ss_n high; req ignored; then -> IDLE.
- Latency:
  - req high in IDLE at edge N: SETUP at N+1, spi_wrt high N+2..N+3.
  - ack is visible one cycle after the spi_done cycle.
- Requester handshake: the requester drops req in the cycle after ack. A req still high when GAP ends is treated as a new request.
- spi_done outside XFER is ignored; no state change.
- req/tgt/wdata changes after grant have no effect on the transaction in flight.
- Simultaneous requests are served round-robin; no requester waits more than NUM_REQ-1 transactions.

Test Plan:
- Single request: req=001, tgt0=0, wdata0=16'h1305; the model returns done 20 cycles later with spi_rd=16'h00A5. Required:
  - ch1_ss_n low for SETUP+XFER only.
  - spi_wrt one pulse 2 cycles after req; spi_cmd=16'h1305.
  - ack=001 one cycle; rdata=16'h00A5; err=000.
- Contention: req=111 held (each requester redrops and reasserts after its ack), targets 3/4/1. Required:
  - Grants in order 0,1,2,0 from reset.
  - trig_ss_n, then EEP_ss_n, then ch2_ss_n, never two low together.
  - At least GAP_CYC all-high cycles between selects.
- Invalid target: req=010, tgt1=6. Required: ack=010 and err=010 together, no spi_wrt, all ss_n stay high, next grant searches from requester 2.
- Timeout: spi_done tied 0, req=100, tgt2=4. Required: EEP_ss_n low for exactly TO_CYC cycles, then ack=100, err=100, rdata unchanged, busy then returns to 0 after GAP.
- Reset mid-XFER: assert rst 5 cycles after spi_wrt. Required:
  - All ss_n high, ack=0, busy=0 after that edge.
  - A late spi_done is ignored.
  - Next req=011 grants requester 0 first.
- Stray done: spi_done pulsed in IDLE and in GAP. Required: no ack, no state change, rdata unchanged.
